// File: rtl/reg_pipe_chain.sv
// Configurable-latency register chain with per-beat valid, clock enable, flush and a
// runtime output tap (tap 0 = bypass). Define REG_PIPE_OCC_EN to add the occ popcount port.
module reg_pipe_chain #(
    parameter int unsigned N            = 18,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned TW           = 5,
    parameter bit          ZERO_INVALID = 1'b0
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          ENABLE,
    input  logic          flush,
    input  logic [TW-1:0] tap_sel,
    input  logic          in_valid,
    input  logic [N-1:0]  in,
    output logic [N-1:0]  out,
    output logic          out_valid
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [TW-1:0] occ
`endif
);

    if (DEPTH == 0) begin : g_bypass
        assign out       = in;
        assign out_valid = in_valid;
`ifdef REG_PIPE_OCC_EN
        assign occ       = '0;
`endif
    end else begin : g_chain
        logic [N-1:0]     s_q [DEPTH];
        logic [N-1:0]     s_d [DEPTH];
        logic [DEPTH-1:0] v_q;
        logic [DEPTH-1:0] v_d;
        logic [TW-1:0]    tap_eff;

        // Shift on enable; flush overrides and discards the incoming beat.
        always_comb begin
            s_d = s_q;
            v_d = v_q;
            if (flush) begin
                for (int k = 0; k < int'(DEPTH); k++) begin
                    s_d[k] = '0;
                end
                v_d = '0;
            end else if (ENABLE) begin
                v_d[0] = in_valid;
                s_d[0] = (ZERO_INVALID && !in_valid) ? '0 : in;
                for (int k = 1; k < int'(DEPTH); k++) begin
                    v_d[k] = v_q[k-1];
                    s_d[k] = (ZERO_INVALID && !v_q[k-1]) ? '0 : s_q[k-1];
                end
            end
        end

        always_ff @(posedge CLK or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < int'(DEPTH); k++) begin
                    s_q[k] <= '0;
                end
                v_q <= '0;
            end else begin
                s_q <= s_d;
                v_q <= v_d;
            end
        end

        // Taps beyond the physical depth read the last stage.
        assign tap_eff = (tap_sel > TW'(DEPTH)) ? TW'(DEPTH) : tap_sel;

        always_comb begin
            out       = in;
            out_valid = in_valid;
            for (int k = 1; k <= int'(DEPTH); k++) begin
                if (tap_eff == TW'(k)) begin
                    out       = s_q[k-1];
                    out_valid = v_q[k-1];
                end
            end
        end

`ifdef REG_PIPE_OCC_EN
        always_comb begin
            occ = '0;
            for (int k = 1; k <= int'(DEPTH); k++) begin
                if ((TW'(k) <= tap_eff) && v_q[k-1]) begin
                    occ = occ + TW'(1);
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_reg_pipe_chain.sv
// Scoreboard bench for reg_pipe_chain: default instance plus a ZERO_INVALID=1 instance.
module tb_reg_pipe_chain;
    localparam int unsigned N     = 18;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 5;

    logic          CLK = 1'b0;
    logic          rst;
    logic          ENABLE;
    logic          flush;
    logic [TW-1:0] tap_sel;
    logic          in_valid;
    logic [N-1:0]  din;
    logic [N-1:0]  out, out_z;
    logic          out_valid, out_valid_z;
`ifdef REG_PIPE_OCC_EN
    logic [TW-1:0] occ, occ_z;
`endif

    reg_pipe_chain #(.N(N), .DEPTH(DEPTH), .TW(TW), .ZERO_INVALID(1'b0)) dut (
        .CLK(CLK), .rst(rst), .ENABLE(ENABLE), .flush(flush), .tap_sel(tap_sel),
        .in_valid(in_valid), .in(din), .out(out), .out_valid(out_valid)
`ifdef REG_PIPE_OCC_EN
        , .occ(occ)
`endif
    );

    reg_pipe_chain #(.N(N), .DEPTH(DEPTH), .TW(TW), .ZERO_INVALID(1'b1)) dut_z (
        .CLK(CLK), .rst(rst), .ENABLE(ENABLE), .flush(flush), .tap_sel(tap_sel),
        .in_valid(in_valid), .in(din), .out(out_z), .out_valid(out_valid_z)
`ifdef REG_PIPE_OCC_EN
        , .occ(occ_z)
`endif
    );

    always #5 CLK = ~CLK;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [N-1:0]  exp_q [$];
    bit            mon_en      = 1'b0;
    bit            adv_q       = 1'b0;

    // A new beat reaches the tap only after an edge that advanced the chain.
    always @(posedge CLK) adv_q <= ENABLE && !flush && !rst;

    always @(negedge CLK) begin
        logic [N-1:0] e;
        if (mon_en && adv_q && out_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: out=%05h presented, no beat expected", out);
            end else begin
                e = exp_q.pop_front();
                if (out !== e) begin
                    miscompares++;
                    $display("FAIL sb_beat: out=%05h, required %05h", out, e);
                end
            end
        end
    end

    task automatic chk_d(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %05h, required %05h", name, got, want);
        end
    endtask

    task automatic chk_b(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

`ifdef REG_PIPE_OCC_EN
    task automatic chk_o(input string name, input logic [TW-1:0] got, input logic [TW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask
`endif

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [N-1:0] d);
        din      = d;
        in_valid = 1'b1;
        exp_q.push_back(d);
        tick();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ENABLE = 1'b0; flush = 1'b0; in_valid = 1'b0; din = '0; tap_sel = 5'd3;
        #2;
        chk_d("reset_out", out, 18'h00000);
        chk_b("reset_valid", out_valid, 1'b0);
`ifdef REG_PIPE_OCC_EN
        chk_o("reset_occ", occ, 5'd0);
`endif
        // Bypass needs no clock edge.
        tap_sel = 5'd0; din = 18'h3FFFF; in_valid = 1'b1;
        #1;
        chk_d("bypass_out", out, 18'h3FFFF);
        chk_b("bypass_valid", out_valid, 1'b1);
        repeat (2) tick();
        rst = 1'b0; in_valid = 1'b0; din = '0;

        // Three beats through tap 3.
        tap_sel = 5'd3; ENABLE = 1'b1; mon_en = 1'b1;
        send(18'h00001);
        send(18'h00002);
        send(18'h00003);
        chk_d("lat3_e3_out", out, 18'h00001);
        chk_b("lat3_e3_valid", out_valid, 1'b1);
`ifdef REG_PIPE_OCC_EN
        chk_o("lat3_occ", occ, 5'd3);
`endif
        in_valid = 1'b0; din = '0;
        tick();
        chk_d("lat3_e4_out", out, 18'h00002);
        tick();
        chk_d("lat3_e5_out", out, 18'h00003);
        repeat (3) tick();
        chk_b("lat3_drained_valid", out_valid, 1'b0);
        chk_i("sb_drain1", exp_q.size(), 0);

        // Hold with ENABLE low, peek at tap 1, then resume.
        tap_sel = 5'd2;
        send(18'h00AAA);
        ENABLE = 1'b0; in_valid = 1'b0; din = 18'h3FFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_b("hold_valid", out_valid, 1'b0);
        end
        tap_sel = 5'd1;
        #1;
        chk_d("tap1_peek_out", out, 18'h00AAA);
        chk_b("tap1_peek_valid", out_valid, 1'b1);
        tap_sel = 5'd2;
        ENABLE = 1'b1;
        tick();
        chk_d("hold_resume_out", out, 18'h00AAA);
        chk_b("hold_resume_valid", out_valid, 1'b1);
        repeat (4) tick();
        chk_i("sb_drain2", exp_q.size(), 0);
        mon_en = 1'b0;

        // Fill, then flush with ENABLE high and a valid input.
        tap_sel = 5'd4;
        for (int i = 1; i <= 4; i++) begin
            din = N'(i * 17); in_valid = 1'b1;
            tick();
        end
        chk_d("full_out", out, 18'h00011);
        chk_b("full_valid", out_valid, 1'b1);
`ifdef REG_PIPE_OCC_EN
        chk_o("full_occ", occ, 5'd4);
`endif
        flush = 1'b1; din = 18'h12345; in_valid = 1'b1;
        tick();
        flush = 1'b0; ENABLE = 1'b0; din = '0; in_valid = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tap_sel = TW'(t);
            #1;
            chk_d("flush_out", out, 18'h00000);
            chk_b("flush_valid", out_valid, 1'b0);
        end
`ifdef REG_PIPE_OCC_EN
        chk_o("flush_occ", occ, 5'd0);
`endif

        // Asynchronous reset between edges with a full chain.
        tap_sel = 5'd3; ENABLE = 1'b1;
        din = 18'h00101; in_valid = 1'b1; tick();
        din = 18'h00202; tick();
        din = 18'h00303; tick();
        chk_d("prerst_out", out, 18'h00101);
        #2;
        rst = 1'b1;
        #1;
        chk_d("async_rst_out", out, 18'h00000);
        chk_b("async_rst_valid", out_valid, 1'b0);
`ifdef REG_PIPE_OCC_EN
        chk_o("async_rst_occ", occ, 5'd0);
`endif
        ENABLE = 1'b0; in_valid = 1'b0; din = '0;
        #3;
        rst = 1'b0;
        tick();

        // ZERO_INVALID bubble with clamped tap.
        tap_sel = 5'd7; ENABLE = 1'b1;
        din = 18'h00155; in_valid = 1'b0; tick();
        din = 18'h000F0; in_valid = 1'b1; tick();
`ifdef REG_PIPE_OCC_EN
        chk_o("zi_occ_e2", occ_z, 5'd1);
`endif
        din = 18'h00155; in_valid = 1'b0;
        tick();
        tick();
        chk_d("zi_e4_out", out_z, 18'h00000);
        chk_b("zi_e4_valid", out_valid_z, 1'b0);
        chk_d("nz_e4_out", out, 18'h00155);
        chk_b("nz_e4_valid", out_valid, 1'b0);
        tick();
        chk_d("zi_e5_out", out_z, 18'h000F0);
        chk_b("zi_e5_valid", out_valid_z, 1'b1);
        chk_d("nz_e5_out", out, 18'h000F0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
